// File: rtl/alu_div_seq.sv
// rtl/alu_div_seq.sv - multi-cycle restoring divider for the ALU DIV/REM class
//
// Purpose: iterative signed/unsigned restoring divider. The execute stage issues
// operands with start, stalls while busy is high, and captures Quot/Rem/DZ on the
// one-cycle done pulse. Each division takes OPERAND_WIDTH restoring steps plus one
// sign-fix cycle. A zero divisor short-circuits straight to DONE.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   begin a division (accepted in IDLE or DONE only)
//   sign   in   1   1 = two's complement operands, 0 = unsigned
//   InA    in   W   dividend
//   InB    in   W   divisor
//   busy   out  1   division in progress (RUN or FIX)
//   done   out  1   one-cycle result-valid pulse
//   Quot   out  W   quotient, held until overwritten by the next result
//   Rem    out  W   remainder, held like Quot
//   DZ     out  1   divide-by-zero flag of the last result
module alu_div_seq #(
    parameter int OPERAND_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     sign,
    input  logic [OPERAND_WIDTH-1:0] InA,
    input  logic [OPERAND_WIDTH-1:0] InB,
    output logic                     busy,
    output logic                     done,
    output logic [OPERAND_WIDTH-1:0] Quot,
    output logic [OPERAND_WIDTH-1:0] Rem,
    output logic                     DZ
);

    localparam int W  = OPERAND_WIDTH;
    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic [W-1:0]    r_quo;
    logic [W-1:0]    r_rem;
    logic [W-1:0]    r_div;
    logic [CW-1:0]   r_cnt;
    logic            r_qneg;
    logic            r_rneg;
    logic [W-1:0]    r_quot;
    logic [W-1:0]    r_rem_out;
    logic            r_dz;

    logic            w_accept;
    logic            w_div_zero;
    logic [W-1:0]    w_abs_a;
    logic [W-1:0]    w_abs_b;
    logic [W:0]      w_rem_sh;
    logic            w_trial_ok;
    logic [W-1:0]    w_trial;

    assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_div_zero = (InB == '0);

    // Magnitudes are kept as unsigned W-bit values, so |0x8000| = 0x8000 is exact.
    assign w_abs_a = (sign && InA[W-1]) ? (~InA + 1'b1) : InA;
    assign w_abs_b = (sign && InB[W-1]) ? (~InB + 1'b1) : InB;

    // Restoring step: shifted partial remainder needs W+1 bits; the trial
    // subtraction is non-negative exactly when the shifted value >= divisor,
    // and then the difference is below the divisor so W bits hold it.
    assign w_rem_sh   = {r_rem, r_quo[W-1]};
    assign w_trial_ok = (w_rem_sh >= {1'b0, r_div});
    assign w_trial    = w_rem_sh[W-1:0] - r_div;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = w_div_zero ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == CW'(1)) begin
                    w_next = S_FIX;
                end
            end
            S_FIX: begin
                busy   = 1'b1;
                w_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) begin
                    w_next = w_div_zero ? S_DONE : S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo     <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_qneg    <= 1'b0;
            r_rneg    <= 1'b0;
            r_quot    <= '0;
            r_rem_out <= '0;
            r_dz      <= 1'b0;
        end else if (w_accept) begin
            if (w_div_zero) begin
                r_quot    <= '1;
                r_rem_out <= InA;
                r_dz      <= 1'b1;
            end else begin
                r_quo  <= w_abs_a;
                r_div  <= w_abs_b;
                r_rem  <= '0;
                r_cnt  <= CW'(W);
                r_qneg <= sign & (InA[W-1] ^ InB[W-1]);
                r_rneg <= sign & InA[W-1];
            end
        end else if (r_state == S_RUN) begin
            r_rem <= w_trial_ok ? w_trial : w_rem_sh[W-1:0];
            r_quo <= {r_quo[W-2:0], w_trial_ok};
            r_cnt <= r_cnt - CW'(1);
        end else if (r_state == S_FIX) begin
            r_quot    <= r_qneg ? (~r_quo + 1'b1) : r_quo;
            r_rem_out <= r_rneg ? (~r_rem + 1'b1) : r_rem;
            r_dz      <= 1'b0;
        end
    end

    assign Quot = r_quot;
    assign Rem  = r_rem_out;
    assign DZ   = r_dz;

endmodule

// File: tb/tb_alu_div_seq.sv
// tb/tb_alu_div_seq.sv - self-checking bench for alu_div_seq
module tb_alu_div_seq;

    localparam int W = 16;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sign;
    logic [W-1:0] InA;
    logic [W-1:0] InB;
    logic         busy;
    logic         done;
    logic [W-1:0] Quot;
    logic [W-1:0] Rem;
    logic         DZ;

    int checks = 0;
    int passed = 0;

    alu_div_seq #(.OPERAND_WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sign  (sign),
        .InA   (InA),
        .InB   (InB),
        .busy  (busy),
        .done  (done),
        .Quot  (Quot),
        .Rem   (Rem),
        .DZ    (DZ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer division truncating toward zero, remainder follows dividend.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
        int sa, sb, iq, ir;
        if (b == 0) begin
            q = '1; r = a; dz = 1'b1;
        end else if (s) begin
            sa = $signed(a); sb = $signed(b);
            iq = sa / sb;    ir = sa % sb;
            q = iq[W-1:0];   r = ir[W-1:0]; dz = 1'b0;
        end else begin
            q = a / b; r = a % b; dz = 1'b0;
        end
    endfunction

    // Drives a start pulse; returns at the first falling edge after the sampling edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        @(negedge clk);
        InA = a; InB = b; sign = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done, counting busy cycles along the way.
    task automatic wait_done(output int busy_cnt, output bit seen, output bit overlap);
        busy_cnt = 0; seen = 1'b0; overlap = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if (busy && done) overlap = 1'b1;
            if (busy) busy_cnt++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sign = 1'b0; InA = '0; InB = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, Quot, Rem, DZ} !== '0)
            $display("FAIL reset_outputs got busy=%0b done=%0b Quot=%h Rem=%h DZ=%0b want all 0",
                     busy, done, Quot, Rem, DZ);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_after_reset got busy=%0b done=%0b want 0 0", busy, done);
        else passed++;
    endtask

    task automatic test_directed();
        logic [W-1:0] ta [8];
        logic [W-1:0] tb [8];
        logic         ts [8];
        logic [W-1:0] eq [8];
        logic [W-1:0] er [8];
        logic         ez [8];
        int bc; bit seen, ov;
        ta = '{16'd100, 16'hFFF9, 16'd7,    16'h1234, 16'h8000, 16'hFFFF, 16'd5, 16'h1234};
        tb = '{16'd7,   16'd2,    16'hFFFE, 16'h0000, 16'hFFFF, 16'd1,    16'd9, 16'h0000};
        ts = '{1'b0,    1'b1,     1'b1,     1'b0,     1'b1,     1'b0,     1'b0,  1'b1};
        eq = '{16'd14,  16'hFFFD, 16'hFFFD, 16'hFFFF, 16'h8000, 16'hFFFF, 16'd0, 16'hFFFF};
        er = '{16'd2,   16'hFFFF, 16'd1,    16'h1234, 16'h0000, 16'h0000, 16'd5, 16'h1234};
        ez = '{1'b0,    1'b0,     1'b0,     1'b1,     1'b0,     1'b0,     1'b0,  1'b1};
        for (int i = 0; i < 8; i++) begin
            issue(ta[i], tb[i], ts[i]);
            wait_done(bc, seen, ov);
            checks++;
            if (!seen) $display("FAIL dir%0d_done got none want pulse", i); else passed++;
            checks++;
            if (bc !== (ez[i] ? 0 : W + 1))
                $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bc, ez[i] ? 0 : W + 1);
            else passed++;
            checks++;
            if (ov) $display("FAIL dir%0d_busy_done_overlap got 1 want 0", i); else passed++;
            checks++;
            if (Quot !== eq[i] || Rem !== er[i] || DZ !== ez[i])
                $display("FAIL dir%0d_result got Q=%h R=%h DZ=%0b want Q=%h R=%h DZ=%0b",
                         i, Quot, Rem, DZ, eq[i], er[i], ez[i]);
            else passed++;
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || Quot !== eq[i] || Rem !== er[i])
                $display("FAIL dir%0d_pulse_hold got done=%0b Q=%h R=%h want 0 %h %h",
                         i, done, Quot, Rem, eq[i], er[i]);
            else passed++;
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, q, r;
        logic s, dz;
        int bc; bit seen, ov;
        for (int i = 0; i < 60; i++) begin
            a = W'($urandom);
            case ($urandom_range(0, 9))
                0:       b = '0;
                1:       b = '1;
                2:       b = W'($urandom_range(1, 3));
                3:       begin b = W'($urandom); a = 16'h8000; end
                default: b = W'($urandom);
            endcase
            s = 1'($urandom);
            model(a, b, s, q, r, dz);
            issue(a, b, s);
            wait_done(bc, seen, ov);
            checks++;
            if (!seen || ov || bc !== (dz ? 0 : W + 1))
                $display("FAIL rnd%0d_handshake got seen=%0b overlap=%0b busy=%0d want 1 0 %0d",
                         i, seen, ov, bc, dz ? 0 : W + 1);
            else passed++;
            checks++;
            if (Quot !== q || Rem !== r || DZ !== dz)
                $display("FAIL rnd%0d_result a=%h b=%h s=%0b got Q=%h R=%h DZ=%0b want Q=%h R=%h DZ=%0b",
                         i, a, b, s, Quot, Rem, DZ, q, r, dz);
            else passed++;
        end
        @(negedge clk);
    endtask

    task automatic test_ignore_busy();
        int bc, extra; bit seen, ov;
        issue(16'd1000, 16'd3, 1'b0);
        repeat (5) @(negedge clk);
        InA = 16'd9; InB = 16'd2; sign = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, seen, ov);
        checks++;
        if (!seen || Quot !== 16'd333 || Rem !== 16'd1 || DZ !== 1'b0)
            $display("FAIL ignore_busy_result got seen=%0b Q=%0d R=%0d DZ=%0b want 1 333 1 0",
                     seen, Quot, Rem, DZ);
        else passed++;
        extra = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (busy || done) extra++;
        end
        checks++;
        if (extra !== 0) $display("FAIL ignore_busy_no_queue got %0d active cycles want 0", extra);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int bc; bit seen, ov;
        issue(16'd100, 16'd7, 1'b0);
        wait_done(bc, seen, ov);
        InA = 16'd50; InB = 16'd5; sign = 1'b0; start = 1'b1;
        checks++;
        if (!seen || Quot !== 16'd14 || Rem !== 16'd2)
            $display("FAIL b2b_first got seen=%0b Q=%0d R=%0d want 1 14 2", seen, Quot, Rem);
        else passed++;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, seen, ov);
        checks++;
        if (!seen || ov || bc !== W + 1)
            $display("FAIL b2b_second_timing got seen=%0b overlap=%0b busy=%0d want 1 0 %0d",
                     seen, ov, bc, W + 1);
        else passed++;
        checks++;
        if (Quot !== 16'd10 || Rem !== 16'd0 || DZ !== 1'b0)
            $display("FAIL b2b_second_result got Q=%0d R=%0d DZ=%0b want 10 0 0", Quot, Rem, DZ);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int bc, stray; bit seen, ov;
        issue(16'd1000, 16'd3, 1'b0);
        repeat (7) @(negedge clk);
        checks++;
        if (busy !== 1'b1) $display("FAIL rst_mid_pre_busy got %0b want 1", busy); else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, Quot, Rem, DZ} !== '0)
            $display("FAIL rst_mid_async got busy=%0b done=%0b Q=%h R=%h DZ=%0b want all 0",
                     busy, done, Quot, Rem, DZ);
        else passed++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        checks++;
        if (stray !== 0) $display("FAIL rst_mid_no_done got %0d active cycles want 0", stray);
        else passed++;
        issue(16'd1000, 16'd7, 1'b0);
        wait_done(bc, seen, ov);
        checks++;
        if (!seen || Quot !== 16'd142 || Rem !== 16'd6 || DZ !== 1'b0)
            $display("FAIL rst_mid_recover got seen=%0b Q=%0d R=%0d DZ=%0b want 1 142 6 0",
                     seen, Quot, Rem, DZ);
        else passed++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
